indirect_csr_arbiter: RTL

INDIRECT_CSR_ARBITER -- requirements
Module: indirect_csr_arbiter

---
 rtl/indirect_csr_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/indirect_csr_arbiter.sv
// indirect_csr_arbiter: round-robin arbiter funnelling NUM_REQ four-phase CSR requesters onto one
// four-phase CSR target. Define INDIRECT_CSR_ARB_TIMEOUT_EN to compile in the target-ack timeout.
module indirect_csr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int CMD_W          = 16,
  parameter int AW             = 19,
  parameter int DW             = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_csr_clk,
  input  logic                 i_csr_rst,
  input  logic [NUM_REQ*CMD_W-1:0] i_req_cmd,
  input  logic [NUM_REQ*AW-1:0]    i_req_addr,
  input  logic [NUM_REQ*DW-1:0]    i_req_writedata,
  output logic [DW-1:0]        o_req_readdata,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [1:0]           o_req_rresp,
  output logic [1:0]           o_req_bresp,
  output logic [CMD_W-1:0]     o_csr_cmd,
  output logic [AW-1:0]        o_csr_addr,
  output logic [DW-1:0]        o_csr_writedata,
  input  logic [DW-1:0]        i_csr_readdata,
  input  logic                 i_csr_ack,
  input  logic [1:0]           i_csr_rresp,
  input  logic [1:0]           i_csr_bresp
);

  // state    | meaning
  // IDLE     | no transaction; arbitrate pending requesters and latch the winner
  // ISSUE    | one cycle: drive the target, or answer an illegal command locally
  // WAIT_ACK | target command held until i_csr_ack (or timeout when compiled in)
  // RESP     | requester ack held until its cmd and the target ack have both dropped

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] CMD_NOOP    = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_ILLEGAL = 2'd3;
  localparam logic [1:0] RESP_ERR    = 2'b10;
  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("indirect_csr_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

  state_t           state;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    grant;
  logic [CMD_W-1:0] lat_cmd;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;

`ifdef INDIRECT_CSR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  logic [NUM_REQ-1:0] pending;
  logic [GW-1:0]      rr_pick;
  logic [GW-1:0]      cand;
  logic [1:0]         grant_code;

  // Scan from the slot after last_grant; the nearest pending requester wins, last_grant itself last.
  always_comb begin
    pending = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      pending[i] = (i_req_cmd[i*CMD_W +: 2] != CMD_NOOP);
    rr_pick = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (pending[cand]) rr_pick = cand;
    end
    grant_code = i_req_cmd[int'(grant)*CMD_W +: 2];
  end

  always_ff @(posedge i_csr_clk) begin
    if (i_csr_rst) begin
      state           <= IDLE;
      last_grant      <= GW'(NUM_REQ - 1);
      grant           <= '0;
      lat_cmd         <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      o_req_ack       <= '0;
      o_req_readdata  <= '0;
      o_req_rresp     <= '0;
      o_req_bresp     <= '0;
      o_csr_cmd       <= '0;
      o_csr_addr      <= '0;
      o_csr_writedata <= '0;
`ifdef INDIRECT_CSR_ARB_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            grant     <= rr_pick;
            lat_cmd   <= i_req_cmd[int'(rr_pick)*CMD_W +: CMD_W];
            lat_addr  <= i_req_addr[int'(rr_pick)*AW +: AW];
            lat_wdata <= i_req_writedata[int'(rr_pick)*DW +: DW];
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (lat_cmd[1:0] == CMD_ILLEGAL) begin
            o_req_readdata <= '0;
            o_req_rresp    <= RESP_ERR;
            o_req_bresp    <= RESP_ERR;
            o_req_ack      <= ACK_ONE << grant;
            state          <= RESP;
          end else begin
            o_csr_cmd       <= lat_cmd;
            o_csr_addr      <= lat_addr;
            o_csr_writedata <= lat_wdata;
`ifdef INDIRECT_CSR_ARB_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
            state           <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (i_csr_ack) begin
            o_csr_cmd <= '0;
            o_req_ack <= ACK_ONE << grant;
            if (lat_cmd[1:0] == CMD_READ) begin
              o_req_readdata <= i_csr_readdata;
              o_req_rresp    <= i_csr_rresp;
              o_req_bresp    <= 2'b00;
            end else begin
              o_req_readdata <= '0;
              o_req_rresp    <= 2'b00;
              o_req_bresp    <= i_csr_bresp;
            end
            state <= RESP;
          end
`ifdef INDIRECT_CSR_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            o_csr_cmd      <= '0;
            o_req_ack      <= ACK_ONE << grant;
            o_req_readdata <= '0;
            o_req_rresp    <= RESP_ERR;
            o_req_bresp    <= RESP_ERR;
            state          <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        // A late target ack after a timeout is simply waited out here.
        RESP: begin
          if (grant_code == CMD_NOOP && !i_csr_ack) begin
            o_req_ack  <= '0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
